// File: rtl/iir_sched_pkg.sv
// Shared types and fixed-point constants for the time-multiplexed IIR MAC sequencer.
package iir_sched_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int X_W   = 11;
  localparam int Y_W   = 36;
  localparam int BC_W  = 12;
  localparam int AC_W  = 15;
  localparam int ACC_W = 48;

  localparam int X_FL = 3;
  localparam int Y_FL = 27;
  localparam int C_FL = 11;

  localparam int NUM_B = 4;
  localparam int NUM_A = 6;

  localparam int ROUND_SHIFT = 11;
  localparam int B_ALIGN     = 13;

  localparam logic signed [Y_W-1:0] Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0] Y_MIN = {1'b1, {(Y_W-1){1'b0}}};
endpackage

// File: rtl/iir_mac_unit.sv
// Combinational MAC slice: picks the coefficient for the current step, multiplies,
// aligns (feedforward) or rounds (feedback) to En27 and adds/subtracts into acc.
module iir_mac_unit import iir_sched_pkg::*; #(
  parameter logic signed [NUM_B-1:0][BC_W-1:0] B_COEF = {12'sd0, 12'sd0, 12'sd0, 12'sd1024},
  parameter logic signed [NUM_A-1:0][AC_W-1:0] A_COEF = '0,
  parameter int ACC_W = 48
) (
  input  logic        [3:0]       step,
  input  logic signed [X_W-1:0]   x_op,
  input  logic signed [Y_W-1:0]   y_op,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_next
);
  localparam int BP_W = BC_W + X_W;
  localparam int AP_W = AC_W + Y_W;

  logic signed [BC_W-1:0]  b_c;
  logic signed [AC_W-1:0]  a_c;
  logic signed [BP_W-1:0]  b_prod;
  logic signed [AP_W-1:0]  a_prod;
  logic signed [AP_W:0]    a_rnd;
  logic signed [ACC_W-1:0] b_term;
  logic signed [ACC_W-1:0] a_term;

  always_comb begin
    b_c = '0;
    a_c = '0;
    for (int i = 0; i < NUM_B; i++)
      if (step == 4'(i)) b_c = B_COEF[i];
    for (int k = 0; k < NUM_A; k++)
      if (step == 4'(NUM_B + k)) a_c = A_COEF[k];

    b_prod = BP_W'(b_c) * BP_W'(x_op);
    a_prod = AP_W'(a_c) * AP_W'(y_op);

    // En14 -> En27 is exact; En38 -> En27 rounds half-up before the shift
    b_term = ACC_W'(b_prod) <<< B_ALIGN;
    a_rnd  = (AP_W+1)'(a_prod) + (AP_W+1)'(1 << (ROUND_SHIFT - 1));
    a_term = ACC_W'(a_rnd >>> ROUND_SHIFT);

    acc_next = (step < 4'(NUM_B)) ? acc + b_term : acc - a_term;
  end
endmodule

// File: rtl/iir_mac_sched.sv
// Even-tap direct-form-I IIR sharing one MAC over 10 steps; result valid 10 edges after accept.
// Holds result until out_ready; no sample accepted outside IDLE.
module iir_mac_sched import iir_sched_pkg::*; #(
  parameter logic signed [NUM_B-1:0][BC_W-1:0] B_COEF = {12'sd0, 12'sd0, 12'sd0, 12'sd1024},
  parameter logic signed [NUM_A-1:0][AC_W-1:0] A_COEF = '0,
  parameter int ACC_W = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic signed [X_W-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic signed [Y_W-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int XH_D = 2 * (NUM_B - 1);
  localparam int YH_D = 2 * NUM_A;
  localparam logic [3:0] LAST = 4'(NUM_B + NUM_A - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(Y_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(Y_MIN);

  state_t state, state_nxt;
  logic        [3:0]       step;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [X_W-1:0]   x_cur;
  logic signed [X_W-1:0]   x_hist [XH_D];
  logic signed [Y_W-1:0]   y_hist [YH_D];
  logic signed [X_W-1:0]   x_op;
  logic signed [Y_W-1:0]   y_op;
  logic signed [Y_W-1:0]   sat_val;

  iir_mac_unit #(.B_COEF(B_COEF), .A_COEF(A_COEF), .ACC_W(ACC_W)) u_mac (
    .step     (step),
    .x_op     (x_op),
    .y_op     (y_op),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // x_cur is x[n]; x_hist[i] is x[n-1-i]; y_hist[j] is y[n-1-j]
  always_comb begin
    x_op = x_cur;
    y_op = y_hist[1];
    for (int s = 1; s < NUM_B; s++)
      if (step == 4'(s)) x_op = x_hist[2*s-1];
    for (int k = 0; k < NUM_A; k++)
      if (step == 4'(NUM_B + k)) y_op = y_hist[2*k+1];
    if (acc_next > SAT_HI)      sat_val = Y_MAX;
    else if (acc_next < SAT_LO) sat_val = Y_MIN;
    else                        sat_val = acc_next[Y_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (step == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      acc      <= '0;
      x_cur    <= '0;
      out_data <= '0;
      for (int i = 0; i < XH_D; i++) x_hist[i] <= '0;
      for (int j = 0; j < YH_D; j++) y_hist[j] <= '0;
    end else if (clk_enable) begin
      state <= state_nxt;
      if (flush) begin
        step  <= '0;
        acc   <= '0;
        x_cur <= '0;
        for (int i = 0; i < XH_D; i++) x_hist[i] <= '0;
        for (int j = 0; j < YH_D; j++) y_hist[j] <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            x_cur     <= in_data;
            x_hist[0] <= x_cur;
            for (int i = 1; i < XH_D; i++) x_hist[i] <= x_hist[i-1];
            acc  <= '0;
            step <= '0;
          end
          MAC: begin
            acc <= acc_next;
            if (step == LAST) out_data <= sat_val;
            else              step     <= step + 4'd1;
          end
          DONE: if (out_ready) begin
            y_hist[0] <= out_data;
            for (int j = 1; j < YH_D; j++) y_hist[j] <= y_hist[j-1];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iir_mac_sched.sv
// Drives four differently-parameterised schedulers in lockstep and compares each against
// a difference-equation reference model.
module tb_iir_mac_sched;
  localparam int ND = 4;
  localparam longint YMAX = (64'sd1 <<< 35) - 64'sd1;
  localparam longint YMIN = -(64'sd1 <<< 35);

  localparam int BC [ND][4] = '{'{1024, 0, 0, 0}, '{1024, 0, 0, 0},
                                '{2047, 2047, 2047, 2047}, '{1023, -517, 301, -77}};
  localparam int AC [ND][6] = '{'{0, 0, 0, 0, 0, 0}, '{-1024, 0, 0, 0, 0, 0},
                                '{0, 0, 0, 0, 0, 0}, '{-333, 211, -97, 45, -13, 7}};

  logic clk = 1'b0;
  logic reset, clk_enable, flush, in_valid, out_ready;
  logic signed [10:0] in_data;
  logic [ND-1:0] in_ready, out_valid, busy;
  logic signed [35:0] out_data [ND];

  int checks = 0;
  int failures = 0;
  longint mx [ND][7];
  longint my [ND][12];
  longint exp_y [ND];
  longint dut_y [ND];

  always #5 clk = ~clk;

  iir_mac_sched u0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready), .busy(busy[0]));

  iir_mac_sched #(.A_COEF({15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, -15'sd1024})) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready), .busy(busy[1]));

  iir_mac_sched #(.B_COEF({4{12'sd2047}})) u2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready), .busy(busy[2]));

  iir_mac_sched #(.B_COEF({-12'sd77, 12'sd301, -12'sd517, 12'sd1023}),
                  .A_COEF({15'sd7, -15'sd13, 15'sd45, -15'sd97, 15'sd211, -15'sd333})) u3 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[3]),
    .out_valid(out_valid[3]), .out_data(out_data[3]), .out_ready(out_ready), .busy(busy[3]));

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 7; i++) mx[d][i] = 0;
      for (int j = 0; j < 12; j++) my[d][j] = 0;
    end
  endfunction

  // y[n] = sum b*x (exact, En27) - sum round_half_up(a*y / 2^11), then clamp to 36 bits
  function automatic longint model_y(int d);
    longint acc = 0;
    longint p;
    for (int s = 0; s < 4; s++) acc += longint'(BC[d][s]) * mx[d][2*s] * 8192;
    for (int k = 0; k < 6; k++) begin
      p = longint'(AC[d][k]) * my[d][2*k+1];
      acc -= (p + 1024) >>> 11;
    end
    if (acc > YMAX) return YMAX;
    if (acc < YMIN) return YMIN;
    return acc;
  endfunction

  task automatic send(input int x, input int rd, input int gap_at, input int gap_len,
                      input bit do_flush, input int flush_at);
    int n;
    for (int d = 0; d < ND; d++) chk($sformatf("idle_rdy%0d", d), in_ready[d], 1);
    in_valid = 1'b1;
    in_data  = 11'(x);
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      for (int i = 6; i > 0; i--) mx[d][i] = mx[d][i-1];
      mx[d][0] = x;
      exp_y[d] = model_y(d);
    end
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 11'($urandom);
    n = 0;
    while (n < 40 && !out_valid[0]) begin
      if (do_flush && n == flush_at) begin
        clk_enable = 1'b1;
        flush      = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("flush_ov%0d", d), out_valid[d], 0);
          chk($sformatf("flush_rdy%0d", d), in_ready[d], 1);
          chk($sformatf("flush_busy%0d", d), busy[d], 0);
        end
        model_clear();
        return;
      end
      chk("mac_busy", busy[0], 1);
      clk_enable = !(n >= gap_at && n < gap_at + gap_len);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    clk_enable = 1'b1;
    chk("latency", n, 10 + gap_len);
    for (int d = 0; d < ND; d++) dut_y[d] = out_data[d];
    for (int i = 0; i <= rd; i++) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("ov%0d", d), out_valid[d], 1);
        chk($sformatf("y%0d", d), out_data[d], exp_y[d]);
        chk($sformatf("done_rdy%0d", d), in_ready[d], 0);
      end
      if (i == rd) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("post_ov%0d", d), out_valid[d], 0);
      for (int j = 11; j > 0; j--) my[d][j] = my[d][j-1];
      my[d][0] = exp_y[d];
    end
  endtask

  initial begin
    int x, rd, gap_at, gap_len, fl_at;
    bit fl;
    longint fb_exp [5] = '{67108864, 0, 33554432, 0, 16777216};
    reset = 1'b1; clk_enable = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 11'sd5; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_ov%0d", d), out_valid[d], 0);
      chk($sformatf("rst_rdy%0d", d), in_ready[d], 1);
      chk($sformatf("rst_busy%0d", d), busy[d], 0);
      chk($sformatf("rst_y%0d", d), out_data[d], 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // impulse through default and first-order feedback instances
    for (int i = 0; i < 5; i++) begin
      send(i == 0 ? 8 : 0, 0, 99, 0, 1'b0, 0);
      chk($sformatf("fb_imp%0d", i), dut_y[1], fb_exp[i]);
      if (i < 2) chk($sformatf("imp%0d", i), dut_y[0], i == 0 ? 67108864 : 0);
    end

    // output clamp at both rails
    repeat (7) send(1023, 0, 99, 0, 1'b0, 0);
    chk("sat_hi", dut_y[2], YMAX);
    repeat (7) send(-1024, 0, 99, 0, 1'b0, 0);
    chk("sat_lo", dut_y[2], YMIN);

    // backpressure, then a sample whose feedback depends on the held result
    send(56, 5, 99, 0, 1'b0, 0);
    send(0, 0, 99, 0, 1'b0, 0);
    send(-3, 0, 99, 0, 1'b0, 0);

    // abort at MAC step 5, then a clean impulse
    send(37, 0, 99, 0, 1'b1, 5);
    send(8, 0, 99, 0, 1'b0, 0);
    chk("imp_after_flush", dut_y[0], 67108864);

    // four frozen cycles mid-MAC
    send(8, 0, 3, 4, 1'b0, 0);
    chk("imp_gap", dut_y[0], 67108864);

    for (int it = 0; it < 40; it++) begin
      x       = int'($urandom_range(0, 2047)) - 1024;
      rd      = int'($urandom_range(0, 3));
      gap_at  = int'($urandom_range(1, 5));
      gap_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      fl      = ($urandom_range(0, 9) == 0);
      fl_at   = int'($urandom_range(0, 9));
      send(x, rd, gap_at, gap_len, fl, fl_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
